// File: rtl/dmux_stream_nway.sv
// Registered 1-to-NUM_OUT valid/ready demultiplexer with per-lane one-entry
// holding registers, broadcast mode and a saturating out-of-range drop counter.
module dmux_stream_nway #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = $clog2(NUM_OUT),
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PAD = 1 << SEL_W;
  localparam logic [SEL_W:0] LANES = (SEL_W+1)'(NUM_OUT);

  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic [PAD-1:0]     free_pad;
  logic               in_range;
  logic               accept;

  // A lane draining on this edge counts as free so it can be refilled without a bubble.
  assign free     = ~out_valid | out_ready;
  assign free_pad = PAD'(free);
  assign in_range = {1'b0, in_sel} < LANES;

  always_comb begin
    if (in_bcast)
      in_ready = &free;
    else if (in_range)
      in_ready = free_pad[in_sel];
    else
      in_ready = 1'b1;
  end

  assign accept = in_valid & in_ready;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    assign load[gi] = accept & (in_bcast | (in_range & (in_sel == SEL_W'(gi))));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else if (load[gi]) begin
        valid_reg <= 1'b1;
        data_reg  <= in_data;
      end else if (out_ready[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign out_valid[gi]                  = valid_reg;
    assign out_data[gi*WIDTH +: WIDTH]    = data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (accept && !in_bcast && !in_range && !(&drop_cnt))
      drop_cnt <= drop_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_dmux_stream_nway.sv
// Scoreboard bench for dmux_stream_nway: an 8-lane instance and a 5-lane instance
// with a 2-bit drop counter, driven by directed sequences and random traffic.
module tb_dmux_stream_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_data  [2];
  logic [2:0]  in_sel   [2];
  logic        in_bcast [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  rdy      [2];

  logic [127:0] out_data0;
  logic [79:0]  out_data1;
  logic [7:0]   out_valid0, out_ready0, drop_cnt0;
  logic [4:0]   out_valid1, out_ready1;
  logic [1:0]   drop_cnt1;

  assign out_ready0 = rdy[0];
  assign out_ready1 = rdy[1][4:0];

  dmux_stream_nway #(.WIDTH(16), .NUM_OUT(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_sel(in_sel[0]),
    .in_bcast(in_bcast[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .drop_cnt(drop_cnt0)
  );

  dmux_stream_nway #(.WIDTH(16), .NUM_OUT(5), .CNT_W(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_sel(in_sel[1]),
    .in_bcast(in_bcast[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .drop_cnt(drop_cnt1)
  );

  // Uniform views of both instances.
  logic [127:0] od [2];
  logic [7:0]   ov [2];
  logic [7:0]   dc [2];
  always_comb begin
    od[0] = out_data0;
    od[1] = {48'd0, out_data1};
    ov[0] = out_valid0;
    ov[1] = {3'd0, out_valid1};
    dc[0] = drop_cnt0;
    dc[1] = {6'd0, drop_cnt1};
  end

  int n_lanes [2] = '{8, 5};
  int cnt_max [2] = '{255, 3};

  // Driver requests applied on the next tick.
  logic        drv_valid [2];
  logic [2:0]  drv_sel   [2];
  logic        drv_bcast [2];
  logic [15:0] drv_data  [2];
  logic [7:0]  drv_rdy   [2];

  // Reference model: words owed by each lane (index d*8+k) and dropped word totals.
  logic [15:0] exp_q [16][$];
  int          drops [2];
  bit          acc   [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic bit lane_free(input int d, input int k);
    return (exp_q[d*8+k].size() == 0) || rdy[d][k];
  endfunction

  function automatic bit model_ready(input int d);
    bit r;
    if (in_bcast[d]) begin
      r = 1'b1;
      for (int k = 0; k < n_lanes[d]; k++) r &= lane_free(d, k);
    end else if (int'(in_sel[d]) < n_lanes[d]) begin
      r = lane_free(d, int'(in_sel[d]));
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  // One clock cycle: apply inputs, check handshake and counter, record accepted words.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = drv_valid[d];
      in_sel[d]   = drv_sel[d];
      in_bcast[d] = drv_bcast[d];
      in_data[d]  = drv_data[d];
      rdy[d]      = drv_rdy[d];
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      bit er;
      er = model_ready(d);
      check("in_ready", d, 32'(in_ready[d]), 32'(er));
      check("drop_cnt", d, 32'(dc[d]), 32'(sat(drops[d], cnt_max[d])));
      acc[d] = drv_valid[d] && er;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        if (drv_bcast[d]) begin
          for (int k = 0; k < n_lanes[d]; k++) exp_q[d*8+k].push_back(drv_data[d]);
        end else if (int'(drv_sel[d]) < n_lanes[d]) begin
          exp_q[d*8+int'(drv_sel[d])].push_back(drv_data[d]);
        end else begin
          drops[d]++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int d, input logic [2:0] s, input logic b, input logic [15:0] data,
                      input int max_wait);
    bit ok;
    ok = 1'b0;
    drv_valid[d] = 1'b1;
    drv_sel[d]   = s;
    drv_bcast[d] = b;
    drv_data[d]  = data;
    for (int i = 0; i < max_wait && !ok; i++) begin
      tick();
      ok = acc[d];
    end
    drv_valid[d] = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout dut%0d: word %h not accepted within %0d cycles", d, data, max_wait);
    end
  endtask

  // Monitor: every cycle compare lane state with the scoreboard, retire words taken by consumers.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          for (int k = 0; k < n_lanes[d]; k++) begin
            bit has;
            has = exp_q[d*8+k].size() > 0;
            check("out_valid", d, 32'(ov[d][k]), 32'(has));
            if (has) begin
              check("out_data", d, 32'(od[d][k*16 +: 16]), 32'(exp_q[d*8+k][0]));
              if (rdy[d][k]) begin
                $display("dut%0d lane%0d delivered %h", d, k, exp_q[d*8+k][0]);
                void'(exp_q[d*8+k].pop_front());
              end
            end
          end
        end
      end
    end
  end

  task automatic check_reset_state();
    check("rst_out_valid", 0, 32'(ov[0]), 32'd0);
    check("rst_out_valid", 1, 32'(ov[1]), 32'd0);
    check("rst_out_data", 0, 32'(od[0] != 128'd0), 32'd0);
    check("rst_out_data", 1, 32'(od[1] != 128'd0), 32'd0);
    check("rst_drop_cnt", 0, 32'(dc[0]), 32'd0);
    check("rst_drop_cnt", 1, 32'(dc[1]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_sel[d] = '0; in_bcast[d] = 1'b0; in_data[d] = '0; rdy[d] = '0;
      drv_valid[d] = 1'b0; drv_sel[d] = '0; drv_bcast[d] = 1'b0; drv_data[d] = '0; drv_rdy[d] = '0;
      drops[d] = 0;
      acc[d] = 1'b0;
    end
    #13;
    check_reset_state();
    #9 rst_n = 1'b1;

    // Walk every lane with consumers always ready.
    drv_rdy[0] = 8'hFF;
    drv_rdy[1] = 8'hFF;
    for (int k = 0; k < 8; k++) send(0, 3'(k), 1'b0, 16'hA0 + 16'(k), 4);
    idle(2);

    // Stalled lane 3 must not block lane 5; second word follows the first with no gap.
    drv_rdy[0] = 8'hF7;
    send(0, 3'd3, 1'b0, 16'h1111, 4);
    drv_valid[0] = 1'b1; drv_sel[0] = 3'd3; drv_bcast[0] = 1'b0; drv_data[0] = 16'h2222;
    tick();
    tick();
    send(0, 3'd5, 1'b0, 16'h5555, 4);
    drv_rdy[0] = 8'hFF;
    send(0, 3'd3, 1'b0, 16'h2222, 4);
    idle(2);

    // Broadcast is all-or-nothing while lane 6 is held.
    drv_rdy[0] = 8'hBF;
    send(0, 3'd6, 1'b0, 16'h6666, 4);
    drv_valid[0] = 1'b1; drv_sel[0] = 3'd0; drv_bcast[0] = 1'b1; drv_data[0] = 16'hBEEF;
    tick();
    tick();
    drv_rdy[0] = 8'hFF;
    send(0, 3'd0, 1'b1, 16'hBEEF, 4);
    idle(2);

    // Back-to-back words into one lane at full rate.
    for (int i = 0; i < 10; i++) send(0, 3'd2, 1'b0, 16'h2000 + 16'(i), 1);
    idle(2);

    // Asynchronous reset between edges with lanes full and drops recorded.
    drv_rdy[0] = 8'h00;
    drv_rdy[1] = 8'h00;
    send(0, 3'd1, 1'b0, 16'h0101, 4);
    send(0, 3'd4, 1'b0, 16'h0404, 4);
    send(1, 3'd1, 1'b0, 16'h1101, 4);
    send(1, 3'd4, 1'b0, 16'h1104, 4);
    send(1, 3'd6, 1'b0, 16'hDEAD, 4);
    send(1, 3'd7, 1'b0, 16'hDEAD, 4);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state();
    for (int i = 0; i < 16; i++) exp_q[i].delete();
    drops[0] = 0;
    drops[1] = 0;
    #1 rst_n = 1'b1;
    drv_rdy[0] = 8'hFF;
    drv_rdy[1] = 8'hFF;
    send(0, 3'd4, 1'b0, 16'h4444, 4);
    idle(2);

    // Out-of-range selects on the 5-lane instance: never stall, counter saturates at 3.
    drv_rdy[1] = 8'h00;
    for (int i = 0; i < 6; i++) send(1, 3'd7, 1'b0, 16'(i), 1);
    idle(2);

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        drv_valid[d] = $urandom_range(0, 9) < 7;
        drv_sel[d]   = 3'($urandom);
        drv_bcast[d] = $urandom_range(0, 9) == 0;
        drv_data[d]  = 16'($urandom);
        for (int k = 0; k < 8; k++) drv_rdy[d][k] = $urandom_range(0, 9) < 6;
      end
      tick();
    end
    drv_rdy[0] = 8'hFF;
    drv_rdy[1] = 8'hFF;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
